// File: rtl/fma_issue_arbiter.sv
// fma_issue_arbiter: round-robin, chain-locked sharing of the FMA abc issue port with result-id tagging.
// Optional per-requester grant and stall counters are enabled by defining FMA_ARB_PERF_EN.
module fma_issue_arbiter #(
  parameter int unsigned REQ_COUNT     = 2,
  parameter int unsigned LINE_WIDTH    = 96,
  parameter int unsigned MAX_BURST     = 16,
  parameter int unsigned ID_FIFO_DEPTH = 4,
  localparam int unsigned IDW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [REQ_COUNT-1:0]            req_valid_in,
  input  logic [REQ_COUNT*LINE_WIDTH-1:0] req_abc_in,
  input  logic [REQ_COUNT-1:0]            req_new_c_in,
  input  logic [REQ_COUNT-1:0]            req_last_in,
  output logic [REQ_COUNT-1:0]            req_ready_out,
  output logic [LINE_WIDTH-1:0]           abc_out,
  output logic                            abc_valid_out,
  output logic                            use_new_c_out,
  output logic                            fma_output_can_be_valid_out,
  input  logic                            fma_valid_in,
  output logic [IDW-1:0]                  result_id_out,
  output logic                            result_valid_out,
  output logic                            busy_out,
  output logic                            error_out
`ifdef FMA_ARB_PERF_EN
  ,
  output logic [REQ_COUNT*16-1:0]         grant_count_out,
  output logic [15:0]                     stall_count_out
`endif
);

  localparam int unsigned BCW = $clog2(MAX_BURST + 1);
  localparam int unsigned PW  = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(ID_FIFO_DEPTH + 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        owner_q, owner_d;
  logic [IDW-1:0]        rr_q, rr_d;
  logic [BCW-1:0]        burst_q, burst_d;
  logic [LINE_WIDTH-1:0] abc_q, abc_d;
  logic                  abc_valid_q, abc_valid_d;
  logic                  use_new_c_q, use_new_c_d;
  logic                  ocv_q, ocv_d;
  logic [IDW-1:0]        rid_q, rid_d;
  logic                  rvalid_q, rvalid_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;
  logic [IDW-1:0]        fifo_q [ID_FIFO_DEPTH];
  logic [IDW-1:0]        fifo_d [ID_FIFO_DEPTH];
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  pick_found;
  logic [IDW-1:0]        pick_idx;
  logic [IDW-1:0]        grant_idx;
  logic                  grant_en;
  logic                  accept;
  logic                  forced;
  logic                  last_eff;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign fifo_full  = (cnt_q == CW'(ID_FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin : rr_pick
    int unsigned idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int unsigned i = 0; i < REQ_COUNT; i++) begin
      idx = (32'(rr_q) + i) % REQ_COUNT;
      if (!pick_found && req_valid_in[IDW'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(idx);
      end
    end
  end

  // A locked chain owns the port; a full id FIFO back-pressures everyone.
  always_comb begin
    grant_idx     = (state_q == S_LOCKED) ? owner_q : pick_idx;
    grant_en      = rst_in && !fifo_full && ((state_q == S_LOCKED) || pick_found);
    req_ready_out = '0;
    if (grant_en) begin
      req_ready_out[grant_idx] = 1'b1;
    end
    accept   = grant_en && req_valid_in[grant_idx];
    forced   = accept && !req_last_in[grant_idx] && (burst_q == BCW'(MAX_BURST - 1));
    last_eff = accept && (req_last_in[grant_idx] || forced);
    push     = last_eff;
    pop      = fma_valid_in && !fifo_empty;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    burst_d     = burst_q;
    abc_d       = abc_q;
    abc_valid_d = 1'b0;
    use_new_c_d = 1'b0;
    ocv_d       = 1'b0;
    rid_d       = rid_q;
    rvalid_d    = 1'b0;
    error_d     = error_q;
    fifo_d      = fifo_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;

    if (accept) begin
      abc_d       = req_abc_in[32'(grant_idx)*LINE_WIDTH +: LINE_WIDTH];
      abc_valid_d = 1'b1;
      use_new_c_d = req_new_c_in[grant_idx];
      ocv_d       = last_eff;
      if (last_eff) begin
        state_d = S_IDLE;
        burst_d = '0;
        rr_d    = (grant_idx == IDW'(REQ_COUNT - 1)) ? '0 : grant_idx + IDW'(1);
      end else begin
        state_d = S_LOCKED;
        owner_d = grant_idx;
        burst_d = burst_q + BCW'(1);
      end
    end

    if (push) begin
      fifo_d[wr_q] = grant_idx;
      wr_d         = wr_q + PW'(1);
    end
    if (pop) begin
      rid_d    = fifo_q[rd_q];
      rvalid_d = 1'b1;
      rd_d     = rd_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (forced || (fma_valid_in && fifo_empty)) begin
      error_d = 1'b1;
    end
    busy_d = (state_d != S_IDLE) || (cnt_d != '0);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_q        <= '0;
      burst_q     <= '0;
      abc_q       <= '0;
      abc_valid_q <= 1'b0;
      use_new_c_q <= 1'b0;
      ocv_q       <= 1'b0;
      rid_q       <= '0;
      rvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      for (int unsigned i = 0; i < ID_FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      burst_q     <= burst_d;
      abc_q       <= abc_d;
      abc_valid_q <= abc_valid_d;
      use_new_c_q <= use_new_c_d;
      ocv_q       <= ocv_d;
      rid_q       <= rid_d;
      rvalid_q    <= rvalid_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      fifo_q      <= fifo_d;
    end
  end

  assign abc_out                     = abc_q;
  assign abc_valid_out               = abc_valid_q;
  assign use_new_c_out               = use_new_c_q;
  assign fma_output_can_be_valid_out = ocv_q;
  assign result_id_out               = rid_q;
  assign result_valid_out            = rvalid_q;
  assign busy_out                    = busy_q;
  assign error_out                   = error_q;

`ifdef FMA_ARB_PERF_EN
  logic [REQ_COUNT*16-1:0] grant_cnt_q, grant_cnt_d;
  logic [15:0]             stall_cnt_q, stall_cnt_d;

  // Accepted beats per requester and cycles where someone waited without an accept.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      grant_cnt_d[32'(grant_idx)*16 +: 16] = grant_cnt_q[32'(grant_idx)*16 +: 16] + 16'd1;
    end else if (|req_valid_in) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_count_out = grant_cnt_q;
  assign stall_count_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fma_issue_arbiter.sv
// tb_fma_issue_arbiter: directed scenarios plus randomized traffic against a queue-based behavioural model.
module tb_fma_issue_arbiter;

  localparam int unsigned N     = 2;
  localparam int unsigned LW    = 96;
  localparam int unsigned MB    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDW   = 1;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic [N-1:0]    req_valid_in;
  logic [N*LW-1:0] req_abc_in;
  logic [N-1:0]    req_new_c_in;
  logic [N-1:0]    req_last_in;
  logic [N-1:0]    req_ready_out;
  logic [LW-1:0]   abc_out;
  logic            abc_valid_out;
  logic            use_new_c_out;
  logic            fma_output_can_be_valid_out;
  logic            fma_valid_in;
  logic [IDW-1:0]  result_id_out;
  logic            result_valid_out;
  logic            busy_out;
  logic            error_out;
`ifdef FMA_ARB_PERF_EN
  logic [N*16-1:0] grant_count_out;
  logic [15:0]     stall_count_out;
`endif

  always #5 clk_in = ~clk_in;

  fma_issue_arbiter #(
    .REQ_COUNT(N), .LINE_WIDTH(LW), .MAX_BURST(MB), .ID_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in                      (clk_in),
    .rst_in                      (rst_in),
    .req_valid_in                (req_valid_in),
    .req_abc_in                  (req_abc_in),
    .req_new_c_in                (req_new_c_in),
    .req_last_in                 (req_last_in),
    .req_ready_out               (req_ready_out),
    .abc_out                     (abc_out),
    .abc_valid_out               (abc_valid_out),
    .use_new_c_out               (use_new_c_out),
    .fma_output_can_be_valid_out (fma_output_can_be_valid_out),
    .fma_valid_in                (fma_valid_in),
    .result_id_out               (result_id_out),
    .result_valid_out            (result_valid_out),
    .busy_out                    (busy_out),
    .error_out                   (error_out)
`ifdef FMA_ARB_PERF_EN
    ,
    .grant_count_out             (grant_count_out),
    .stall_count_out             (stall_count_out)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: lock flag, owner, rr pointer, beat count, and a queue of finished-chain ids.
  bit          m_locked;
  int          m_owner;
  int          m_rr;
  int          m_beats;
  bit          m_err;
  int          m_q[$];
  int          m_gcnt[N];
  int          m_stall;
  logic [LW-1:0] e_abc;
  bit          e_valid, e_newc, e_ocv, e_rv, e_busy;
  int          e_rid;
  logic [N-1:0] last_ready;

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_q.size() >= DEPTH) return r;
    if (m_locked) begin
      r[m_owner] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr + k) % N;
      if (req_valid_in[c]) begin
        r[c] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_rr = 0; m_beats = 0; m_err = 0;
    m_q.delete();
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    m_stall = 0;
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic [N-1:0] nc, input logic [N-1:0] l, input logic f);
    req_valid_in = v;
    req_new_c_in = nc;
    req_last_in  = l;
    fma_valid_in = f;
    for (int b = 0; b < N*LW; b++) req_abc_in[b] = 1'($urandom_range(0, 1));
  endtask

  // One clock: check comb ready, advance the model, then check registered outputs after the edge.
  task automatic step();
    logic [N-1:0] er;
    int g;
    bit fin, forced;
    #1;
    er = model_ready();
    last_ready = req_ready_out;
    check_eq("ready", 128'(req_ready_out), 128'(er));
    g = -1;
    for (int i = 0; i < N; i++) if (er[i] && req_valid_in[i]) g = i;
    e_rv = 0;
    if (fma_valid_in) begin
      if (m_q.size() == 0) m_err = 1;
      else begin
        e_rv  = 1;
        e_rid = m_q.pop_front();
      end
    end
    e_valid = (g >= 0);
    e_newc  = 0;
    e_ocv   = 0;
    if (g >= 0) begin
      e_abc  = req_abc_in[g*LW +: LW];
      e_newc = req_new_c_in[g];
      m_beats++;
      forced = !req_last_in[g] && (m_beats == MB);
      fin    = req_last_in[g] || forced;
      if (forced) m_err = 1;
      e_ocv = fin;
      if (fin) begin
        m_locked = 0; m_beats = 0; m_rr = (g + 1) % N;
        m_q.push_back(g);
      end else begin
        m_locked = 1; m_owner = g;
      end
      m_gcnt[g] = (m_gcnt[g] + 1) & 32'hFFFF;
    end else if (|req_valid_in) begin
      m_stall = (m_stall + 1) & 32'hFFFF;
    end
    e_busy = m_locked || (m_q.size() != 0);
    @(posedge clk_in);
    #1;
    check_eq("abc_valid", 128'(abc_valid_out), 128'(e_valid));
    if (e_valid) begin
      check_eq("abc", 128'(abc_out), 128'(e_abc));
      check_eq("use_new_c", 128'(use_new_c_out), 128'(e_newc));
      check_eq("out_can_be_valid", 128'(fma_output_can_be_valid_out), 128'(e_ocv));
    end
    check_eq("result_valid", 128'(result_valid_out), 128'(e_rv));
    if (e_rv) check_eq("result_id", 128'(result_id_out), 128'(e_rid));
    check_eq("error", 128'(error_out), 128'(m_err));
    check_eq("busy", 128'(busy_out), 128'(e_busy));
`ifdef FMA_ARB_PERF_EN
    for (int i = 0; i < N; i++) check_eq("grant_count", 128'(grant_count_out[i*16 +: 16]), 128'(m_gcnt[i]));
    check_eq("stall_count", 128'(stall_count_out), 128'(m_stall));
`endif
  endtask

  task automatic do_reset(input int cycles);
    rst_in = 1'b0;
    set_in('1, '1, '1, 1'b1);
    repeat (cycles) begin
      #1;
      check_eq("rst_ready", 128'(req_ready_out), 128'(0));
      @(posedge clk_in);
      #1;
    end
    check_eq("rst_abc", 128'(abc_out), 128'(0));
    check_eq("rst_abc_valid", 128'(abc_valid_out), 128'(0));
    check_eq("rst_use_new_c", 128'(use_new_c_out), 128'(0));
    check_eq("rst_ocv", 128'(fma_output_can_be_valid_out), 128'(0));
    check_eq("rst_result", 128'({result_valid_out, result_id_out}), 128'(0));
    check_eq("rst_busy_err", 128'({busy_out, error_out}), 128'(0));
`ifdef FMA_ARB_PERF_EN
    check_eq("rst_perf", 128'({grant_count_out, stall_count_out}), 128'(0));
`endif
    model_reset();
    rst_in = 1'b1;
    set_in('0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [N-1:0] rr_seq [4];
    rr_seq[0] = 2'b01; rr_seq[1] = 2'b10; rr_seq[2] = 2'b01; rr_seq[3] = 2'b10;
    rst_in = 1'b0;
    set_in('0, '0, '0, 1'b0);
    @(posedge clk_in);
    #1;
    do_reset(3);

    // Single-beat chains from both: alternate grants, then fill the id FIFO and stall.
    for (int k = 0; k < 4; k++) begin
      set_in(2'b11, 2'b11, 2'b11, 1'b0);
      step();
      check_eq("rr_grant", 128'(last_ready), 128'(rr_seq[k]));
    end
    set_in(2'b11, 2'b11, 2'b11, 1'b0);
    step();
    check_eq("full_stall", 128'(last_ready), 128'(0));
    set_in(2'b11, 2'b11, 2'b11, 1'b1);
    step();
    check_eq("first_result_id", 128'({result_valid_out, result_id_out}), 128'(2'b10));
    set_in(2'b11, 2'b11, 2'b11, 1'b0);
    step();
    check_eq("stall_release", 128'(last_ready), 128'(2'b01));

    // Three-beat chain on req0 with req1 waiting.
    do_reset(1);
    set_in(2'b11, 2'b01, 2'b00, 1'b0); step();
    check_eq("chain_newc_first", 128'(use_new_c_out), 128'(1));
    set_in(2'b11, 2'b00, 2'b00, 1'b0); step();
    check_eq("chain_lock", 128'(last_ready), 128'(2'b01));
    check_eq("chain_newc_mid", 128'(use_new_c_out), 128'(0));
    set_in(2'b11, 2'b00, 2'b01, 1'b0); step();
    check_eq("chain_ocv_last", 128'(fma_output_can_be_valid_out), 128'(1));
    set_in(2'b11, 2'b10, 2'b10, 1'b0); step();
    check_eq("chain_handover", 128'(last_ready), 128'(2'b10));

    // Runaway chain: forced release on beat MB.
    do_reset(1);
    for (int k = 1; k <= MB; k++) begin
      set_in(2'b11, (k == 1) ? 2'b01 : 2'b00, 2'b00, 1'b0);
      step();
      if (k == MB - 1) check_eq("burst_no_err_yet", 128'({fma_output_can_be_valid_out, error_out}), 128'(0));
    end
    check_eq("burst_forced", 128'({fma_output_can_be_valid_out, error_out}), 128'(2'b11));
    set_in(2'b11, 2'b00, 2'b00, 1'b0); step();
    check_eq("burst_next_owner", 128'(last_ready), 128'(2'b10));

    // Result pulse on empty FIFO, then reset in the middle of a locked chain.
    do_reset(1);
    set_in(2'b00, 2'b00, 2'b00, 1'b1); step();
    check_eq("underflow", 128'({result_valid_out, error_out}), 128'(2'b01));
    do_reset(1);
    set_in(2'b01, 2'b01, 2'b00, 1'b0); step();
    check_eq("locked_busy", 128'(busy_out), 128'(1));
    do_reset(1);
    set_in(2'b10, 2'b10, 2'b00, 1'b0); step();
    check_eq("post_reset_req1", 128'(last_ready), 128'(2'b10));

    // Randomized traffic with occasional resets.
    do_reset(1);
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] v, l, nc;
      if ($urandom_range(0, 299) == 0) do_reset(1 + $urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        v[i]  = ($urandom_range(0, 3) != 0);
        l[i]  = ($urandom_range(0, 3) == 0);
        nc[i] = 1'($urandom_range(0, 1));
      end
      set_in(v, nc, l, ($urandom_range(0, 4) == 0));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
